ifft8_seq: RTL

- Sequential 8-point inverse FFT. It is the return path for the team's combinational 8-point forward FFT.
- Accepts 8 complex frequency bins serially, computes radix-2 DIT IFFT with one time-shared butterfly, and streams 8 complex time samples out.
- Output includes the 1/N scaling, so a forward-then-inverse round trip restores the original samples within rounding error.
- Sits between the spectral-processing stage and the sample sink. Both sides use valid/ready handshakes.

---
 rtl/ifft8_pkg.sv | 39 +++
 rtl/ifft_butterfly.sv | 61 ++++++
 rtl/ifft8_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ifft8_pkg.sv
// Shared types and constants for the 8-point sequential IFFT.
package ifft8_pkg;

  localparam int N     = 8;
  localparam int LOG2N = 3;

  // Twiddle table precision: Q1.15
  localparam int TWQ_W = 16;
  localparam logic signed [TWQ_W-1:0] TW_C = 16'sd23170;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [TWQ_W-1:0] re;
    logic signed [TWQ_W-1:0] im;
  } tw_t;

  // Inverse twiddle W^-t. Entries 0 and 2 are nominal only: the butterfly
  // handles them exactly without a multiply (1 is not representable in Q1.15).
  function automatic tw_t tw_lookup(input logic [1:0] t);
    tw_t w;
    case (t)
      2'd0:    begin w.re = 16'sd32767; w.im = 16'sd0;     end
      2'd1:    begin w.re = TW_C;       w.im = TW_C;       end
      2'd2:    begin w.re = 16'sd0;     w.im = 16'sd32767; end
      default: begin w.re = -TW_C;      w.im = TW_C;       end
    endcase
    return w;
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 DIT inverse butterfly with per-stage halving.
// A' = (A + B*W) >>> 1, B' = (A - B*W) >>> 1.
module ifft_butterfly
  import ifft8_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TW_W   = TWQ_W
) (
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic        [1:0]        tidx,
  output logic signed [DATA_W-1:0] ao_re,
  output logic signed [DATA_W-1:0] ao_im,
  output logic signed [DATA_W-1:0] bo_re,
  output logic signed [DATA_W-1:0] bo_im
);

  localparam int XW = DATA_W + 1;         // T width
  localparam int PW = DATA_W + TW_W + 1;  // full-precision product sum
  localparam int SW = DATA_W + 2;         // A +/- T width

  tw_t                     tw;
  logic signed [TW_W-1:0]  w_re, w_im;
  logic signed [PW-1:0]    p_re, p_im;
  logic signed [XW-1:0]    m_re, m_im, t_re, t_im;
  logic signed [SW-1:0]    s_re, s_im, d_re, d_im;

  assign tw   = tw_lookup(tidx);
  assign w_re = tw.re;
  assign w_im = tw.im;

  // Full complex product, then floor back to Q0 by the twiddle fraction bits
  assign p_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
  assign p_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
  assign m_re = XW'(p_re >>> (TW_W - 1));
  assign m_im = XW'(p_im >>> (TW_W - 1));

  // Exact paths for W=1 and W=j bypass the multiplier result
  always_comb begin
    t_re = m_re;
    t_im = m_im;
    case (tidx)
      2'd0: begin t_re = XW'(b_re);  t_im = XW'(b_im); end
      2'd2: begin t_re = -XW'(b_im); t_im = XW'(b_re); end
      default: ;
    endcase
  end

  assign s_re = SW'(a_re) + SW'(t_re);
  assign s_im = SW'(a_im) + SW'(t_im);
  assign d_re = SW'(a_re) - SW'(t_re);
  assign d_im = SW'(a_im) - SW'(t_im);

  assign ao_re = DATA_W'(s_re >>> 1);
  assign ao_im = DATA_W'(s_im >>> 1);
  assign bo_re = DATA_W'(d_re >>> 1);
  assign bo_im = DATA_W'(d_im >>> 1);

endmodule

// File: rtl/ifft8_seq.sv
// Sequential 8-point IFFT: serial bin load (bit-reversed), 12 in-place
// butterfly cycles, natural-order serial unload. Output is scaled by 1/8.
module ifft8_seq
  import ifft8_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TW_W   = TWQ_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic        [2:0]        out_idx,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  logic signed [DATA_W-1:0] mem_re [N];
  logic signed [DATA_W-1:0] mem_im [N];

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] bf;
  logic [1:0] stg, j, tidx;
  logic [2:0] a_addr, b_addr, nxt_idx;
  logic signed [DATA_W-1:0] ao_re, ao_im, bo_re, bo_im;

  assign stg     = bf[3:2];
  assign j       = bf[1:0];
  assign nxt_idx = out_idx + 3'd1;

  // Butterfly j of stage s: span 1/2/4, twiddle (j % span) * (4 >> s)
  always_comb begin
    a_addr = {j, 1'b0};
    b_addr = {j, 1'b1};
    tidx   = 2'd0;
    case (stg)
      2'd1: begin
        a_addr = {j[1], 1'b0, j[0]};
        b_addr = {j[1], 1'b1, j[0]};
        tidx   = {j[0], 1'b0};
      end
      2'd2: begin
        a_addr = {1'b0, j};
        b_addr = {1'b1, j};
        tidx   = j;
      end
      default: ;
    endcase
  end

  ifft_butterfly #(.DATA_W(DATA_W), .TW_W(TW_W)) u_bfly (
    .a_re (mem_re[a_addr]),
    .a_im (mem_im[a_addr]),
    .b_re (mem_re[b_addr]),
    .b_im (mem_im[b_addr]),
    .tidx (tidx),
    .ao_re(ao_re),
    .ao_im(ao_im),
    .bo_re(bo_re),
    .bo_im(bo_im)
  );

  // Frame buffer: bit-reversed writes on load, in-place writeback on compute
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && in_ready) begin
      mem_re[bitrev3(cnt)] <= in_re;
      mem_im[bitrev3(cnt)] <= in_im;
    end else if (state == COMPUTE) begin
      mem_re[a_addr] <= ao_re;
      mem_im[a_addr] <= ao_im;
      mem_re[b_addr] <= bo_re;
      mem_im[b_addr] <= bo_im;
    end
  end

  // Control FSM with registered handshake and output signals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      cnt       <= '0;
      bf        <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_re    <= '0;
      out_im    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state    <= COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              bf       <= '0;
            end
          end
        end
        COMPUTE: begin
          bf <= bf + 4'd1;
          if (bf == 4'd11) begin
            state <= UNLOAD;
            bf    <= '0;
          end
        end
        UNLOAD: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_re    <= mem_re[0];
            out_im    <= mem_im[0];
          end else if (out_ready) begin
            if (out_idx == 3'd7) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              out_idx  <= nxt_idx;
              out_last <= (nxt_idx == 3'd7);
              out_re   <= mem_re[nxt_idx];
              out_im   <= mem_im[nxt_idx];
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
